// File: rtl/call_return_unit_if.sv
// Decoder/PC-register side bundle for the call/return unit.
// Latency: combinational branch outputs; depth/flags are registered in the unit.
// No backpressure: every request is consumed in the cycle it is presented.
interface call_return_unit_if #(
    parameter int AW         = 7,
    parameter int DEPTH_LOG2 = 2
);
    logic [AW-1:0]         pc_i;
    logic                  jmp_i;
    logic                  jz_i;
    logic                  zero_i;
    logic                  call_i;
    logic                  ret_i;
    logic [AW-1:0]         target_i;
    logic                  branch_en_o;
    logic [AW-1:0]         branch_addr_o;
    logic [DEPTH_LOG2:0]   depth_o;
    logic                  overflow_o;
    logic                  underflow_o;

    // Requester side: decoder / PC register
    modport master (
        output pc_i, jmp_i, jz_i, zero_i, call_i, ret_i, target_i,
        input  branch_en_o, branch_addr_o, depth_o, overflow_o, underflow_o
    );

    // Unit side
    modport slave (
        input  pc_i, jmp_i, jz_i, zero_i, call_i, ret_i, target_i,
        output branch_en_o, branch_addr_o, depth_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/call_return_unit.sv
// Jump/branch/call/return front end with a hardware return-address stack.
// Latency: branch enable/address are combinational (zero cycle); stack updates on the same posedge.
// No backpressure: overflowing calls and underflowing returns are dropped and flagged sticky.
module call_return_unit #(
    parameter int AW         = 7,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    call_return_unit_if.slave  bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] SP_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] SP_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = DEPTH_LOG2'(1);
    localparam logic [AW-1:0]       PC_ONE  = AW'(1);

    logic [AW-1:0]         r_stack [DEPTH];
    logic [DEPTH_LOG2:0]   r_sp;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic [DEPTH_LOG2-1:0] w_top_idx;
    logic                  w_push;
    logic                  w_pop;

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SP_FULL);
    // Low bits of sp address the next free slot; sp-1 wraps correctly when sp==DEPTH.
    assign w_wr_idx  = r_sp[DEPTH_LOG2-1:0];
    assign w_top_idx = w_wr_idx - IDX_ONE;

    // RET outranks CALL, so a simultaneous call is discarded with no push.
    assign w_push = !rst_i && !bus.ret_i && bus.call_i && !w_full;
    assign w_pop  = !rst_i && bus.ret_i && !w_empty;

    // Branch decode in priority order ret > call > jz > jmp; reset masks everything.
    always_comb begin
        bus.branch_en_o   = 1'b0;
        bus.branch_addr_o = bus.target_i;
        if (rst_i) begin
            bus.branch_en_o = 1'b0;
        end else if (bus.ret_i) begin
            bus.branch_en_o   = !w_empty;
            bus.branch_addr_o = r_stack[w_top_idx];
        end else if (bus.call_i) begin
            bus.branch_en_o = !w_full;
        end else if (bus.jz_i) begin
            bus.branch_en_o = bus.zero_i;
        end else if (bus.jmp_i) begin
            bus.branch_en_o = 1'b1;
        end
    end

    // Stack pointer and sticky error flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.ret_i) begin
            if (w_empty) r_underflow <= 1'b1;
            else         r_sp        <= r_sp - SP_ONE;
        end else if (bus.call_i) begin
            if (w_full)  r_overflow  <= 1'b1;
            else         r_sp        <= r_sp + SP_ONE;
        end
    end

    // Return-address storage; contents need no reset since sp gates every read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_stack[w_wr_idx] <= bus.pc_i + PC_ONE;
        end
    end

    assign bus.depth_o     = r_sp;
    assign bus.overflow_o  = r_overflow;
    assign bus.underflow_o = r_underflow;

    logic w_unused;
    assign w_unused = w_pop;
endmodule

// File: tb/tb_call_return_unit.sv
// Directed bench for call_return_unit with a queue-based scoreboard.
// Branch outputs checked mid-cycle; depth/flags checked just after the edge.
// Runs a fixed number of cycles and always ends with a summary line.
module tb_call_return_unit;
    localparam int AW = 7;
    localparam int DL = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    call_return_unit_if #(.AW(AW), .DEPTH_LOG2(DL)) bus ();

    call_return_unit #(.AW(AW), .DEPTH_LOG2(DL)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%0d required=<queued value>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    // One request cycle: drive, check combinational branch, clock, check state.
    task automatic step(input string name,
                        input logic rst, input logic jmp, input logic jz, input logic zero,
                        input logic call, input logic ret,
                        input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                        input logic exp_en, input logic chk_addr, input logic [AW-1:0] exp_addr,
                        input logic [DL:0] exp_depth, input logic exp_ovf, input logic exp_udf);
        rst_i        = rst;
        bus.jmp_i    = jmp;
        bus.jz_i     = jz;
        bus.zero_i   = zero;
        bus.call_i   = call;
        bus.ret_i    = ret;
        bus.pc_i     = pc;
        bus.target_i = tgt;
        push_exp({name, ".en"}, 32'(exp_en));
        if (chk_addr) push_exp({name, ".addr"}, 32'(exp_addr));
        @(negedge clk_i);
        check(32'(bus.branch_en_o));
        if (chk_addr) check(32'(bus.branch_addr_o));
        push_exp({name, ".depth"}, 32'(exp_depth));
        push_exp({name, ".ovf"}, 32'(exp_ovf));
        push_exp({name, ".udf"}, 32'(exp_udf));
        @(posedge clk_i);
        #1;
        check(32'(bus.depth_o));
        check(32'(bus.overflow_o));
        check(32'(bus.underflow_o));
    endtask

    initial begin
        bus.jmp_i = 0; bus.jz_i = 0; bus.zero_i = 0; bus.call_i = 0; bus.ret_i = 0;
        bus.pc_i = '0; bus.target_i = '0;
        @(posedge clk_i);
        #1;
        //    name        rst jmp jz z call ret  pc   tgt  en  ca addr dep ovf udf
        step("reset",      1, 0, 0, 0, 0, 0,   0,   0,  0, 0,  0,  0, 0, 0);
        step("rst_jmp",    1, 1, 0, 0, 0, 0,   0,  33,  0, 0,  0,  0, 0, 0);
        step("idle",       0, 0, 0, 0, 0, 0,   0,   0,  0, 0,  0,  0, 0, 0);
        step("call1",      0, 0, 0, 0, 1, 0,  10,  40,  1, 1, 40,  1, 0, 0);
        step("ret1",       0, 0, 0, 0, 0, 1,  40,   0,  1, 1, 11,  0, 0, 0);
        step("nest_a",     0, 0, 0, 0, 1, 0,   5,  60,  1, 1, 60,  1, 0, 0);
        step("nest_b",     0, 0, 0, 0, 1, 0,  20,  61,  1, 1, 61,  2, 0, 0);
        step("nest_c",     0, 0, 0, 0, 1, 0,  30,  62,  1, 1, 62,  3, 0, 0);
        step("nest_d",     0, 0, 0, 0, 1, 0,  50,  63,  1, 1, 63,  4, 0, 0);
        step("call_full",  0, 0, 0, 0, 1, 0,  70,  80,  0, 0,  0,  4, 1, 0);
        step("ret_d",      0, 0, 0, 0, 0, 1,   0,   0,  1, 1, 51,  3, 1, 0);
        step("ret_c",      0, 0, 0, 0, 0, 1,   0,   0,  1, 1, 31,  2, 1, 0);
        step("ret_b",      0, 0, 0, 0, 0, 1,   0,   0,  1, 1, 21,  1, 1, 0);
        step("ret_a",      0, 0, 0, 0, 0, 1,   0,   0,  1, 1,  6,  0, 1, 0);
        step("ret_empty",  0, 0, 0, 0, 0, 1,   0,   0,  0, 0,  0,  0, 1, 1);
        step("call_wrap",  0, 0, 0, 0, 1, 0, 127,  10,  1, 1, 10,  1, 1, 1);
        step("ret_wrap",   0, 0, 0, 0, 0, 1,   0,   0,  1, 1,  0,  0, 1, 1);
        step("jz_nz",      0, 0, 1, 0, 0, 0,   0,  99,  0, 0,  0,  0, 1, 1);
        step("jz_z",       0, 0, 1, 1, 0, 0,   0,  99,  1, 1, 99,  0, 1, 1);
        step("jmp",        0, 1, 0, 0, 0, 0,   0,  77,  1, 1, 77,  0, 1, 1);
        step("jz_over_jmp",0, 1, 1, 0, 0, 0,   0,  55,  0, 0,  0,  0, 1, 1);
        step("call_12",    0, 0, 0, 0, 1, 0,  11,  20,  1, 1, 20,  1, 1, 1);
        step("call_ret",   0, 0, 0, 0, 1, 1,  20,  33,  1, 1, 12,  0, 1, 1);
        step("ret_after",  0, 0, 0, 0, 0, 1,   0,   0,  0, 0,  0,  0, 1, 1);
        step("call_x",     0, 0, 0, 0, 1, 0,   1,  90,  1, 1, 90,  1, 1, 1);
        step("call_y",     0, 0, 0, 0, 1, 0,   2,  91,  1, 1, 91,  2, 1, 1);
        step("rst_d2",     1, 1, 0, 0, 0, 1,   0,  44,  0, 0,  0,  0, 0, 0);
        step("post_rst",   0, 0, 0, 0, 0, 0,   0,   0,  0, 0,  0,  0, 0, 0);

        if (sb_q.size() != 0) begin
            n_bad++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/call_return_unit.md
Name: call_return_unit

Overview:
- Control-flow front end that sits ahead of the PC register and drives its branch interface (branch enable + 7-bit branch address).
- Decodes jump, conditional jump, call and return requests from the decoder.
- Keeps a hardware return-address stack so that CALL/RET work without data-memory traffic.
- Reads the current PC back from the PC register to form return addresses.

Parameters:
- AW, 7: program address width; matches the 7-bit PC.
- DEPTH_LOG2, 2: log2 of the return-stack depth; DEPTH = 2**DEPTH_LOG2 = 4 entries.

Ports:
- clk_i  input  1  clock; all state updates on the posedge.
- rst_i  input  1  synchronous, active-high reset.
- pc_i  input  AW  current PC from the PC register.
- jmp_i  input  1  unconditional jump request.
- jz_i  input  1  jump-if-zero request.
- zero_i  input  1  ALU zero flag, sampled in the same cycle as jz_i.
- call_i  input  1  call request; pushes the return address.
- ret_i  input  1  return request; pops the return address.
- target_i  input  AW  jump/call target address.
- branch_en_o  output  1  to PC register: take branch this edge.
- branch_addr_o  output  AW  to PC register: branch destination.
- depth_o  output  DEPTH_LOG2+1  current stack occupancy, 0..DEPTH.
- overflow_o  output  1  sticky: a call was attempted with the stack full.
- underflow_o  output  1  sticky: a return was attempted with the stack empty.

Behaviour:
- State:
  - stack array of DEPTH x AW.
  - sp (DEPTH_LOG2+1 bits) = number of valid entries.
  - overflow and underflow flags.
  - depth_o = sp.
- Reset (rst_i=1 at posedge): sp=0, overflow_o=0, underflow_o=0. Stack contents are don't-care.
- While rst_i=1, branch_en_o is forced to 0 combinationally; branch_addr_o is don't-care. Reset overrides any request in the same cycle.
- branch_en_o and branch_addr_o are combinational from the current-cycle inputs and the stack top. Zero latency: the PC register samples them at the same posedge at which the stack updates.
- Request priority when several are asserted: ret_i > call_i > jz_i > jmp_i. Lower-priority requests are ignored entirely, with no stack effect.
- RET, sp>0:
  - branch_en_o=1, branch_addr_o=stack[sp-1].
  - At the posedge, sp decrements.
- RET, sp=0:
  - branch_en_o=0, so the PC advances by one.
  - At the posedge, underflow_o sets; sp stays 0.
- CALL, sp<DEPTH:
  - branch_en_o=1, branch_addr_o=target_i.
  - At the posedge, stack[sp] <= pc_i+1, truncated to AW bits (pc 127 -> return address 0); sp increments.
- CALL, sp=DEPTH:
  - branch_en_o=0 (call suppressed); the stack is unchanged.
  - At the posedge, overflow_o sets.
- JZ: branch_en_o=zero_i, branch_addr_o=target_i. No stack effect.
- JMP: branch_en_o=1, branch_addr_o=target_i. No stack effect.
- No request: branch_en_o=0, branch_addr_o=target_i (value irrelevant).
- Sticky flags clear only on reset. They have no effect on later operation: after an overflow or underflow, later calls and returns behave normally within bounds.
- Every active request is consumed in exactly one cycle. Back-to-back CALL/RET on consecutive cycles is legal and must see the updated sp.

Test Plan:
- Reset, then idle: depth_o=0, both flags 0, branch_en_o=0; with rst_i=1 and jmp_i=1, branch_en_o stays 0.
- pc_i=10, call_i=1, target_i=40 -> branch_en_o=1, branch_addr_o=40, then depth_o=1. Next cycle pc_i=40, ret_i=1 -> branch_en_o=1, branch_addr_o=11, then depth_o=0.
- Nested calls from pc 5, 20, 30, 50 fill the stack (depth_o=4). A fifth call -> branch_en_o=0, overflow_o=1, depth_o=4. Four returns yield 51, 31, 21, 6 in that order.
- ret_i=1 on an empty stack -> branch_en_o=0, underflow_o=1, depth_o=0. A following call with pc_i=127 pushes 0; the next ret yields branch_addr_o=0.
- jz_i=1, target_i=99: with zero_i=0 -> branch_en_o=0; with zero_i=1 -> branch_en_o=1, branch_addr_o=99. depth_o is unchanged in both cases.
- call_i=1 and ret_i=1 together with depth 1 (top=12) -> return taken to 12, depth_o=0, nothing pushed. Then rst_i asserted with depth 2 -> depth_o=0 and flags cleared.
